ring_buffer: RTL and testbench

Single-clock circular FIFO buffering captured data words between a producer (bus capture logic) and a slower consumer (e.g. a serial transmitter). Storage is 2^AW words of DW bits, addressed by wrapping read/write pointers. One slot is kept unused, so usable capacity is 2^AW-1 words. Reports empty and "overflow" (buffer full, no further room) to the surrounding logic.

---
 rtl/ring_buffer.sv | 81 ++++++++
 tb/tb_ring_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer.sv
// ring_buffer: single-clock circular FIFO of 2^AW words x DW bits.
// One slot is always left unused, so the usable capacity is 2^AW-1 words
// and full/empty can both be derived from the two pointers alone.
//
// Strobe semantics: write_clock_enable and read_clock_enable are
// level-sensitive. Every rising edge with a strobe high attempts one
// operation. A write is accepted only if overflow is low before the edge.
// A read is accepted only if empty is low before the edge. A refused
// operation leaves all state untouched. Both flags are evaluated on the
// pre-edge pointers, so a simultaneous read+write on a full buffer
// performs only the read. On an empty buffer it performs only the write,
// with no bypass to read_data.
module ring_buffer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] write_data,
  input  logic          write_clock_enable,
  input  logic          read_clock_enable,
  output logic [DW-1:0] read_data,
  output logic          empty,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] rd_ptr_inc;
  logic [DW-1:0] read_data_q, read_data_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_write;
  logic          do_read;

  // Flags come straight from the registered pointers; wrap is natural modulo 2^AW.
  assign wr_ptr_inc = wr_ptr_q + AW'(1);
  assign rd_ptr_inc = rd_ptr_q + AW'(1);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign overflow   = (wr_ptr_inc == rd_ptr_q);
  assign do_write   = write_clock_enable && !overflow;
  assign do_read    = read_clock_enable && !empty;
  assign read_data  = read_data_q;

  // Next-state for pointers and the output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    read_data_d = read_data_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_inc;
    end
    if (do_read) begin
      rd_ptr_d    = rd_ptr_inc;
      read_data_d = mem_q[rd_ptr_q];
    end
  end

  // Pointer and read_data registers; reset discards any stored words.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      read_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      read_data_q <= read_data_d;
    end
  end

  // Storage array; contents survive reset, writes are blocked during reset.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_ring_buffer.sv
// tb_ring_buffer: directed and random stimulus for ring_buffer at AW=2, DW=2.
// A queue holds the words the buffer should contain; accepted writes push,
// accepted reads pop into the expected read_data value.
module tb_ring_buffer;

  localparam int AW  = 2;
  localparam int DW  = 2;
  localparam int CAP = (1 << AW) - 1;

  logic          clock;
  logic          reset;
  logic [DW-1:0] write_data;
  logic          write_clock_enable;
  logic          read_clock_enable;
  logic [DW-1:0] read_data;
  logic          empty;
  logic          overflow;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd;
  int            tests;
  int            failed;

  ring_buffer #(.AW(AW), .DW(DW)) dut (
    .clock              (clock),
    .reset              (reset),
    .write_data         (write_data),
    .write_clock_enable (write_clock_enable),
    .read_clock_enable  (read_clock_enable),
    .read_data          (read_data),
    .empty              (empty),
    .overflow           (overflow)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".read_data"}, 8'(read_data), 8'(exp_rd));
    check({tag, ".empty"},     8'(empty),     8'(exp_q.size() == 0));
    check({tag, ".overflow"},  8'(overflow),  8'(exp_q.size() == CAP));
  endtask

  // Drive one edge with the given strobes, then update the expected model.
  task automatic step(input logic wen, input logic ren, input logic [DW-1:0] d,
                      input string tag);
    int pre;
    write_clock_enable = wen;
    read_clock_enable  = ren;
    write_data         = d;
    @(posedge clock);
    #1;
    pre = exp_q.size();
    if (ren && pre > 0)   exp_rd = exp_q.pop_front();
    if (wen && pre < CAP) exp_q.push_back(d);
    write_clock_enable = 1'b0;
    read_clock_enable  = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int edges, input string tag);
    reset              = 1'b1;
    write_clock_enable = 1'b1;
    read_clock_enable  = 1'b1;
    write_data         = 2'b10;
    repeat (edges) @(posedge clock);
    #1;
    reset              = 1'b0;
    write_clock_enable = 1'b0;
    read_clock_enable  = 1'b0;
    exp_q.delete();
    exp_rd = '0;
    check_state(tag);
    check({tag, ".rd_zero"}, 8'(read_data), 8'h00);
    check({tag, ".empty1"},  8'(empty),     8'h01);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests  = 0;
    failed = 0;
    exp_rd = '0;
    reset  = 1'b0;
    write_data         = '0;
    write_clock_enable = 1'b0;
    read_clock_enable  = 1'b0;
    @(posedge clock);
    #1;

    // 1. Reset held two edges, strobes high to show reset priority.
    do_reset(2, "reset");
    check("reset.ovf0", 8'(overflow), 8'h00);

    // 2. Read on empty is ignored.
    step(1'b0, 1'b1, 2'b11, "rd_empty");
    check("rd_empty.rd", 8'(read_data), 8'h00);

    // 3. Write then a two-edge read.
    step(1'b1, 1'b0, 2'b11, "wr1");
    step(1'b0, 1'b1, 2'b00, "rd1a");
    check("rd1a.rd", 8'(read_data), 8'h03);
    check("rd1a.empty", 8'(empty), 8'h01);
    step(1'b0, 1'b1, 2'b00, "rd1b");
    check("rd1b.rd", 8'(read_data), 8'h03);

    // 4. Fill, dropped write, read back.
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, 2'b11, "fill");
    check("fill.ovf", 8'(overflow), 8'h01);
    step(1'b1, 1'b0, 2'b01, "wr_full");
    check("wr_full.ovf", 8'(overflow), 8'h01);
    for (int i = 0; i < CAP; i++) begin
      step(1'b0, 1'b1, 2'b00, "rd_fill");
      check("rd_fill.rd", 8'(read_data), 8'h03);
    end

    // 5. Drain from full.
    for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, 2'(i), "refill");
    step(1'b0, 1'b1, 2'b00, "drain0");
    check("drain0.ovf", 8'(overflow), 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, "drain");
    check("drain.empty", 8'(empty), 8'h01);
    check("drain.rd", 8'(read_data), 8'h02);

    // 6. Wrap and ordering: 0,1,2 in, 2 out, 3,0 in, rest out.
    step(1'b1, 1'b0, 2'd0, "wrap_w0");
    step(1'b1, 1'b0, 2'd1, "wrap_w1");
    step(1'b1, 1'b0, 2'd2, "wrap_w2");
    step(1'b0, 1'b1, 2'd0, "wrap_r0");
    check("wrap_r0.rd", 8'(read_data), 8'h00);
    step(1'b0, 1'b1, 2'd0, "wrap_r1");
    check("wrap_r1.rd", 8'(read_data), 8'h01);
    step(1'b1, 1'b0, 2'd3, "wrap_w3");
    step(1'b1, 1'b0, 2'd0, "wrap_w4");
    step(1'b0, 1'b1, 2'd0, "wrap_r2");
    check("wrap_r2.rd", 8'(read_data), 8'h02);
    step(1'b0, 1'b1, 2'd0, "wrap_r3");
    check("wrap_r3.rd", 8'(read_data), 8'h03);
    step(1'b0, 1'b1, 2'd1, "wrap_r4");
    check("wrap_r4.rd", 8'(read_data), 8'h00);
    check("wrap_r4.empty", 8'(empty), 8'h01);

    // Simultaneous read+write: empty (write only, no bypass).
    step(1'b1, 1'b1, 2'd3, "rw_empty");
    check("rw_empty.rd", 8'(read_data), 8'h00);
    check("rw_empty.empty", 8'(empty), 8'h00);
    // Non-empty: count unchanged.
    step(1'b1, 1'b0, 2'd1, "rw_pre");
    step(1'b1, 1'b1, 2'd2, "rw_mid");
    check("rw_mid.rd", 8'(read_data), 8'h03);
    check("rw_mid.count", 8'(exp_q.size()), 8'h02);
    // Full: read only, overflow clears.
    step(1'b1, 1'b0, 2'd0, "rw_fill");
    check("rw_fill.ovf", 8'(overflow), 8'h01);
    step(1'b1, 1'b1, 2'd3, "rw_full");
    check("rw_full.rd", 8'(read_data), 8'h01);
    check("rw_full.ovf", 8'(overflow), 8'h00);

    // Reset mid-stream.
    do_reset(1, "mid_reset");

    // Random phase.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
